univ_shift_register: RTL

Parametrised universal shift register, the next generation of the datapath's 10-bit load/clear/shift-left register. Adds selectable shift modes (logical left/right, rotate, arithmetic right), a multi-cycle burst shift of a programmed amount with busy/done handshake, and serial output. It sits in the same datapath slots as the earlier register and is the default for new operand and accumulator registers.

---
 rtl/univ_shift_register_if.sv | 31 +++
 rtl/univ_shift_register.sv | 113 +++++++++++
 2 files changed

// File: rtl/univ_shift_register_if.sv
// Bus bundle for the universal shift register: control/data in, register state out.
interface univ_shift_register_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned AMTW  = $clog2(WIDTH + 1)
);
  logic             sclr;
  logic             sload;
  logic [WIDTH-1:0] pin;
  logic [1:0]       mode;
  logic             serin_l;
  logic             serin_r;
  logic             sshift;
  logic             start;
  logic [AMTW-1:0]  amt;
  logic [WIDTH-1:0] pout;
  logic             serout;
  logic             busy;
  logic             done;

  // Controller side: drives commands, observes the register.
  modport master (
    output sclr, sload, pin, mode, serin_l, serin_r, sshift, start, amt,
    input  pout, serout, busy, done
  );

  // Register side.
  modport slave (
    input  sclr, sload, pin, mode, serin_l, serin_r, sshift, start, amt,
    output pout, serout, busy, done
  );
endinterface

// File: rtl/univ_shift_register.sv
// Universal shift register: load/clear, single-step shifts in four modes, and a
// multi-cycle burst shift with busy/done handshake. All outputs come straight from flops.
module univ_shift_register #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned AMTW  = $clog2(WIDTH + 1)
) (
  input logic                  clk,
  input logic                  rst,
  univ_shift_register_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             serout_q, serout_d;
  logic [AMTW-1:0]  cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       shift_mode;
  logic [WIDTH:0]   shift_res;  // {expelled bit, new register value}
  logic [AMTW-1:0]  amt_sat;

  // Returns {expelled bit, shifted value} for the given mode.
  function automatic logic [WIDTH:0] shift_fn(input logic [1:0]       m,
                                              input logic [WIDTH-1:0] p,
                                              input logic             sl,
                                              input logic             sr);
    logic [WIDTH:0] r;
    unique case (m)
      2'b00:   r = {p[WIDTH-1], p[WIDTH-2:0], sl};
      2'b01:   r = {p[0], sr, p[WIDTH-1:1]};
      2'b10:   r = {p[WIDTH-1], p[WIDTH-2:0], p[WIDTH-1]};
      default: r = {p[0], p[WIDTH-1], p[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // Burst uses the mode latched at start; single steps use the live mode.
  always_comb begin
    shift_mode = (state_q == StRun) ? mode_q : bus.mode;
    shift_res  = shift_fn(shift_mode, p_q, bus.serin_l, bus.serin_r);
    amt_sat    = (bus.amt > AMTW'(WIDTH)) ? AMTW'(WIDTH) : bus.amt;
  end

  // Next-state: rst > sclr > burst step > sload > start > sshift.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    serout_d = serout_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    if (rst) begin
      state_d  = StIdle;
      p_d      = '0;
      serout_d = 1'b0;
      cnt_d    = '0;
      mode_d   = '0;
    end else if (bus.sclr) begin
      state_d  = StIdle;
      p_d      = '0;
      serout_d = 1'b0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          p_d      = shift_res[WIDTH-1:0];
          serout_d = shift_res[WIDTH];
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == AMTW'(1)) state_d = StDone;
        end
        StDone: state_d = StIdle;
        default: begin
          if (bus.sload) begin
            p_d = bus.pin;
          end else if (bus.start) begin
            if (amt_sat == '0) begin
              state_d = StDone;
            end else begin
              state_d = StRun;
              cnt_d   = amt_sat;
              mode_d  = bus.mode;
            end
          end else if (bus.sshift) begin
            p_d      = shift_res[WIDTH-1:0];
            serout_d = shift_res[WIDTH];
          end
        end
      endcase
    end
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  // State register; reset is applied synchronously through the next-state logic.
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    p_q      <= p_d;
    serout_q <= serout_d;
    cnt_q    <= cnt_d;
    mode_q   <= mode_d;
    busy_q   <= busy_d;
    done_q   <= done_d;
  end

  assign bus.pout   = p_q;
  assign bus.serout = serout_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
